mkr_pin_mux_seq: RTL
====================

// Module: mkr_pin_mux_seq
// PURPOSE
//  Parametrised, registered pin multiplexer for the MKR/NINA/PCIe header pins.
//  Per pin: select GPIO (PIO out/dir) or one of 2**SEL_W-1 alternate peripheral outputs.
//  Mode changes pass a tristate guard interval, so two drivers never meet on a pin.
//  Synchronises pin inputs back to the PIO domain. Instantiated once per pin bank.
// PARAMETERS
//  PINS         32  number of pins in the bank (1..32)
//  SEL_W        2   select width per pin; source count NSRC = 2**SEL_W (index 0 = PIO)
//  SYNC_STAGES  2   input synchroniser depth (>=2)
//  GUARD_CYC    2   tristate cycles on a mode change (>=1, <=15)
// PORTS
//  iCLK       in   1              system clock; single clock domain
//  iRESETn    in   1              synchronous reset, active-low
//  iMSEL      in   PINS*SEL_W     requested source per pin; pin i uses bits [i*SEL_W +: SEL_W]
//  iPIO_OUT   in   PINS           GPIO output value
//  iPIO_DIR   in   PINS           GPIO direction (1 = drive)
//  iALT_OUT   in   PINS*(NSRC-1)  alternate outputs; source s (1..NSRC-1) of pin i at [(s-1)*PINS+i]
//  iPIN_IN    in   PINS           raw pad inputs
//  oPIN_OUT   out  PINS           registered pad output value
//  oPIN_OE    out  PINS           registered pad output enable (top level applies tristate)
//  oPIO_IN    out  PINS           synchronised pad input
//  oBUSY      out  1              OR of all pins in GUARD
// BEHAVIOUR
//  Reset (iRESETn=0 at posedge): oPIN_OE=0, oPIN_OUT=0, oPIO_IN=0, oBUSY=0.
//    Active sel=0, every pin ACTIVE, guard counter 0, sync chains 0.
//  Per-pin FSM: ACTIVE, GUARD.
//   ACTIVE: if iMSEL[i] != active sel -> GUARD. Load target=iMSEL[i], cnt=GUARD_CYC-1.
//     OE goes 0 at the next edge.
//   GUARD: OE=0, OUT=0. If iMSEL[i] != target: reload target and restart cnt.
//     Else if cnt==0: active sel=target, state ACTIVE. Else cnt--.
//   The pin is undriven for exactly GUARD_CYC cycles if the request is stable.
//  ACTIVE output, registered, 1-cycle latency from inputs:
//    sel 0  : OE=iPIO_DIR[i], OUT=iPIO_DIR[i] ? iPIO_OUT[i] : 0
//    sel s>0: OE=1, OUT=iALT_OUT[(s-1)*PINS+i]
//    A change in PIO dir/out does not go through the guard.
//  oPIO_IN: SYNC_STAGES-flop chain per pin. Latency SYNC_STAGES cycles, regardless of mode.
//  oBUSY is registered and asserts in the same cycle as the first guard cycle.
//  Reset during GUARD: pin returns to ACTIVE sel 0, OE=0 next cycle.
//  Pins are independent. Simultaneous changes on several pins each guard in parallel.
// CONFIGURATION
//  PIN_IRQ_EN defined: extra ports iIRQ_RISE[PINS], iIRQ_FALL[PINS], iIRQ_CLR[PINS],
//    oIRQ_STAT[PINS], oIRQ (1).
//   - Edges are detected on the last two sync stages.
//   - A matching enabled edge sets the sticky oIRQ_STAT[i].
//   - iIRQ_CLR[i] clears it. A set and a clear in the same cycle: set wins.
//   - oIRQ = |oIRQ_STAT, registered. Reset clears all status.
//  PIN_IRQ_EN undefined: the IRQ ports and logic are absent. Behaviour is otherwise identical.
// STRUCTURE
//  Package mkr_pin_mux_pkg: state enum {ST_ACTIVE, ST_GUARD}, SEL_PIO=0 constant, cnt width (4).
//  Sub-module mkr_pin_mux_slice: one pin (FSM, counter, output reg, sync chain, optional IRQ).
//    It is generated PINS times. The top level ORs the busy flags and slices the buses.
// TESTING
//  T1 reset:
//    Hold iRESETn=0 with all inputs 1 -> oPIN_OE=0, oPIN_OUT=0, oPIO_IN=0, oBUSY=0.
//  T2 PIO path:
//    Set iMSEL=0, then iPIO_DIR[3]=1, iPIO_OUT[3]=1 -> oPIN_OE[3]=1 and oPIN_OUT[3]=1 after 1 cycle.
//    Set DIR[3]=0 -> OE[3]=0 after 1 cycle.
//  T3 guard, GUARD_CYC=2:
//    Change pin 5 from sel 0 (driving) to sel 2 with iALT_OUT[PINS+5]=1.
//    -> OE[5]=0 for exactly 2 cycles and oBUSY=1.
//    -> Then OE[5]=1 and OUT[5]=1, and oBUSY=0.
//  T4 retarget in guard:
//    Change sel 0->1, then after 1 cycle change to 3.
//    -> The guard restarts. Total OE=0 time is 3 cycles, then source 3 is driven.
//  T5 sync:
//    Toggle iPIN_IN[7] 0->1 -> oPIO_IN[7] rises exactly SYNC_STAGES=2 cycles later.
//  T6 PIN_IRQ_EN:
//    Set iIRQ_RISE[7]=1 and raise pin 7 -> oIRQ_STAT[7]=1 and oIRQ=1.
//    Pulse iIRQ_CLR[7] on a cycle with a new rising edge -> status stays 1.
//    Pulse the clear alone -> status goes 0.

Source files
------------

// File: rtl/mkr_pin_mux_pkg.sv
// ============================================================================
// Module : mkr_pin_mux_pkg
// Brief  : Shared types and constants for the MKR header pin multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mkr_pin_mux_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GUARD  = 1'b1
    } pin_state_t;

    localparam int SEL_PIO = 0;
    localparam int CNT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/mkr_pin_mux_slice.sv
// ============================================================================
// Module : mkr_pin_mux_slice
// Brief  : One pin: source select with tristate guard, input synchroniser,
//          optional edge IRQ (PIN_IRQ_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mkr_pin_mux_slice #(
    parameter int  SEL_W       = 2,
    parameter int  SYNC_STAGES = 2,
    parameter int  GUARD_CYC   = 2,
    localparam int NSRC        = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] msel,
    input  logic             pio_out,
    input  logic             pio_dir,
    input  logic [NSRC-2:0]  alt_out,
    input  logic             pin_in,
`ifdef PIN_IRQ_EN
    input  logic             irq_rise,
    input  logic             irq_fall,
    input  logic             irq_clr,
    output logic             irq_stat,
`endif
    output logic             pin_out,
    output logic             pin_oe,
    output logic             pio_in,
    output logic             busy
);

    import mkr_pin_mux_pkg::*;

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

    pin_state_t             state;
    logic [SEL_W-1:0]       active_sel;
    logic [SEL_W-1:0]       target;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic [NSRC-1:0]        src_out;
    logic                   drv_oe;
    logic                   drv_out;

    // Whenever the pin is driven, msel equals the source being driven
    // (steady ACTIVE or guard completion), so msel indexes the source mux.
    assign src_out = {alt_out, pio_dir & pio_out};
    assign drv_oe  = (msel == SEL_W'(SEL_PIO)) ? pio_dir : 1'b1;
    assign drv_out = src_out[msel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ACTIVE;
            active_sel <= '0;
            target     <= '0;
            cnt        <= '0;
            pin_oe     <= 1'b0;
            pin_out    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (msel != active_sel) begin
                        state   <= ST_GUARD;
                        target  <= msel;
                        cnt     <= GUARD_LOAD;
                        pin_oe  <= 1'b0;
                        pin_out <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        pin_oe  <= drv_oe;
                        pin_out <= drv_out;
                        busy    <= 1'b0;
                    end
                end
                ST_GUARD: begin
                    if (msel != target) begin
                        target  <= msel;
                        cnt     <= GUARD_LOAD;
                        pin_oe  <= 1'b0;
                        pin_out <= 1'b0;
                        busy    <= 1'b1;
                    end else if (cnt == '0) begin
                        state      <= ST_ACTIVE;
                        active_sel <= target;
                        pin_oe     <= drv_oe;
                        pin_out    <= drv_out;
                        busy       <= 1'b0;
                    end else begin
                        cnt     <= cnt - 1'b1;
                        pin_oe  <= 1'b0;
                        pin_out <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin_in};
        end
    end

    assign pio_in = sync[SYNC_STAGES-1];

`ifdef PIN_IRQ_EN
    logic edge_rise;
    logic edge_fall;

    assign edge_rise = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
    assign edge_fall = ~sync[SYNC_STAGES-2] & sync[SYNC_STAGES-1];

    // A new edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_stat <= 1'b0;
        end else if ((edge_rise & irq_rise) | (edge_fall & irq_fall)) begin
            irq_stat <= 1'b1;
        end else if (irq_clr) begin
            irq_stat <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mkr_pin_mux_seq.sv
// ============================================================================
// Module : mkr_pin_mux_seq
// Brief  : Registered pin multiplexer for one header pin bank; optional edge
//          interrupts when PIN_IRQ_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mkr_pin_mux_seq
    import mkr_pin_mux_pkg::*;
#(
    parameter int  PINS        = 32,
    parameter int  SEL_W       = 2,
    parameter int  SYNC_STAGES = 2,
    parameter int  GUARD_CYC   = 2,
    localparam int NSRC        = 2**SEL_W
) (
    input  logic                       iCLK,
    input  logic                       iRESETn,
    input  logic [PINS*SEL_W-1:0]      iMSEL,
    input  logic [PINS-1:0]            iPIO_OUT,
    input  logic [PINS-1:0]            iPIO_DIR,
    input  logic [PINS*(NSRC-1)-1:0]   iALT_OUT,
    input  logic [PINS-1:0]            iPIN_IN,
`ifdef PIN_IRQ_EN
    input  logic [PINS-1:0]            iIRQ_RISE,
    input  logic [PINS-1:0]            iIRQ_FALL,
    input  logic [PINS-1:0]            iIRQ_CLR,
    output logic [PINS-1:0]            oIRQ_STAT,
    output logic                       oIRQ,
`endif
    output logic [PINS-1:0]            oPIN_OUT,
    output logic [PINS-1:0]            oPIN_OE,
    output logic [PINS-1:0]            oPIO_IN,
    output logic                       oBUSY
);

    logic [PINS-1:0] busy_vec;

    for (genvar i = 0; i < PINS; i++) begin : g_pin
        logic [NSRC-2:0] alt_pin;

        // Alternate outputs arrive grouped by source; gather this pin's set.
        for (genvar s = 1; s < NSRC; s++) begin : g_alt
            assign alt_pin[s-1] = iALT_OUT[(s-1)*PINS + i];
        end

        mkr_pin_mux_slice #(
            .SEL_W       (SEL_W),
            .SYNC_STAGES (SYNC_STAGES),
            .GUARD_CYC   (GUARD_CYC)
        ) u_slice (
            .clk      (iCLK),
            .rst_n    (iRESETn),
            .msel     (iMSEL[i*SEL_W +: SEL_W]),
            .pio_out  (iPIO_OUT[i]),
            .pio_dir  (iPIO_DIR[i]),
            .alt_out  (alt_pin),
            .pin_in   (iPIN_IN[i]),
`ifdef PIN_IRQ_EN
            .irq_rise (iIRQ_RISE[i]),
            .irq_fall (iIRQ_FALL[i]),
            .irq_clr  (iIRQ_CLR[i]),
            .irq_stat (oIRQ_STAT[i]),
`endif
            .pin_out  (oPIN_OUT[i]),
            .pin_oe   (oPIN_OE[i]),
            .pio_in   (oPIO_IN[i]),
            .busy     (busy_vec[i])
        );
    end

    assign oBUSY = |busy_vec;

`ifdef PIN_IRQ_EN
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            oIRQ <= 1'b0;
        end else begin
            oIRQ <= |oIRQ_STAT;
        end
    end
`endif

endmodule

`default_nettype wire
